add_seq_ctrl: RTL and testbench



---
 rtl/add_seq_ctrl_if.sv | 28 ++
 rtl/add_seq_ctrl.sv | 154 +++++++++++++++
 tb/tb_add_seq_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/add_seq_ctrl_if.sv
// Handshake and data bundle between operand producer, add sequencer and
// result consumer. The master side drives operands and out_ready; the
// slave side (the sequencer) drives in_ready and the result.
interface add_seq_ctrl_if #(
  parameter int WIDTH = 32
);
  // operand side
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             c_in;
  // result side
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_out;

  modport master (
    output in_valid, x, y, c_in, out_ready,
    input  in_ready, out_valid, s, c_out
  );

  modport slave (
    input  in_valid, x, y, c_in, out_ready,
    output in_ready, out_valid, s, c_out
  );
endinterface

// File: rtl/add_seq_ctrl.sv
// Multi-precision add sequencer. A WIDTH-bit sum is built by running one
// CHUNK-bit ripple-carry adder over WIDTH/CHUNK cycles, least-significant
// chunk first, with the inter-chunk carry held in a register. WIDTH must
// be an integer multiple of CHUNK.

// Plain n-bit ripple-carry adder built from a chain of full adders.
module rca_nbit #(
  parameter int n = 8
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic         ci,
  output logic [n-1:0] sum,
  output logic         co
);
  logic [n:0] carry;

  assign carry[0] = ci;

  for (genvar gi = 0; gi < n; gi++) begin : g_fa
    assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
  end

  assign co = carry[n];
endmodule

module add_seq_ctrl #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  add_seq_ctrl_if.slave bus
);
  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_reg;
  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] opa_reg;
  logic [WIDTH-1:0] opb_reg;
  logic             carry_reg;
  logic [WIDTH-1:0] s_reg;
  logic             c_out_reg;

  logic             accept;
  logic             release_res;
  logic             last_chunk;
  logic [31:0]      chunk_base;
  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK-1:0] sum_chunk;
  logic             carry_next;
  logic [WIDTH-1:0] chunk_mask;
  logic [WIDTH-1:0] s_next;

  // Handshake outputs are decoded from state alone, so there is no
  // combinational path from any input to any output.
  assign bus.in_ready  = (state_reg == ST_IDLE);
  assign bus.out_valid = (state_reg == ST_DONE);
  assign bus.s         = s_reg;
  assign bus.c_out     = c_out_reg;

  assign accept      = (state_reg == ST_IDLE) && bus.in_valid;
  assign release_res = (state_reg == ST_DONE) && bus.out_ready;
  assign last_chunk  = (cnt_reg == CW'(NCH - 1));

  // Bit offset of the chunk currently being processed.
  assign chunk_base = 32'(cnt_reg) * 32'(CHUNK);

  // Shift-based chunk select keeps the mux free of out-of-range part selects.
  assign a_chunk = CHUNK'(opa_reg >> chunk_base);
  assign b_chunk = CHUNK'(opb_reg >> chunk_base);

  rca_nbit #(.n(CHUNK)) u_rca (
    .a   (a_chunk),
    .b   (b_chunk),
    .ci  (carry_reg),
    .sum (sum_chunk),
    .co  (carry_next)
  );

  // Merge the fresh chunk sum into the result word at the current offset.
  always_comb begin
    chunk_mask = {WIDTH{1'b0}};
    s_next     = s_reg;
    chunk_mask = WIDTH'({CHUNK{1'b1}}) << chunk_base;
    s_next     = (s_reg & ~chunk_mask) | ((WIDTH'(sum_chunk) << chunk_base) & chunk_mask);
  end

  // Control FSM: IDLE -> RUN (NCH chunk cycles) -> DONE -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: if (accept)      state_reg <= ST_RUN;
        ST_RUN:  if (last_chunk)  state_reg <= ST_DONE;
        ST_DONE: if (release_res) state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Chunk counter: cleared on accept, stepped every RUN cycle, wraps on exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (accept) begin
      cnt_reg <= '0;
    end else if (state_reg == ST_RUN) begin
      if (last_chunk) cnt_reg <= '0;
      else            cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // Operands are sampled only on the accept edge; later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_reg <= '0;
      opb_reg <= '0;
    end else if (accept) begin
      opa_reg <= bus.x;
      opb_reg <= bus.y;
    end
  end

  // Inter-chunk carry: seeded with c_in on accept, then fed back from the adder.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_reg <= 1'b0;
    end else if (accept) begin
      carry_reg <= bus.c_in;
    end else if (state_reg == ST_RUN) begin
      carry_reg <= carry_next;
    end
  end

  // Result word and final carry; untouched outside RUN so DONE holds them stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg     <= '0;
      c_out_reg <= 1'b0;
    end else if (state_reg == ST_RUN) begin
      s_reg <= s_next;
      if (last_chunk) c_out_reg <= carry_next;
    end
  end
endmodule

// File: tb/tb_add_seq_ctrl.sv
// Directed and random checks of add_seq_ctrl in four (WIDTH, CHUNK)
// configurations: (32,8), (32,32), (16,1), (16,4).
module tb_add_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Per-instance drive and observe arrays (index = configuration number).
  logic [31:0] drv_x  [4];
  logic [31:0] drv_y  [4];
  logic        drv_c  [4];
  logic        drv_iv [4];
  logic        drv_or [4];
  logic [31:0] obs_s  [4];
  logic        obs_co [4];
  logic        obs_ov [4];
  logic        obs_ir [4];

  add_seq_ctrl_if #(.WIDTH(32)) bus0 ();
  add_seq_ctrl_if #(.WIDTH(32)) bus1 ();
  add_seq_ctrl_if #(.WIDTH(16)) bus2 ();
  add_seq_ctrl_if #(.WIDTH(16)) bus3 ();

  add_seq_ctrl #(.WIDTH(32), .CHUNK(8))  dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  add_seq_ctrl #(.WIDTH(32), .CHUNK(32)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  add_seq_ctrl #(.WIDTH(16), .CHUNK(1))  dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));
  add_seq_ctrl #(.WIDTH(16), .CHUNK(4))  dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  assign bus0.in_valid = drv_iv[0];  assign bus0.x = drv_x[0];        assign bus0.y = drv_y[0];
  assign bus0.c_in = drv_c[0];       assign bus0.out_ready = drv_or[0];
  assign bus1.in_valid = drv_iv[1];  assign bus1.x = drv_x[1];        assign bus1.y = drv_y[1];
  assign bus1.c_in = drv_c[1];       assign bus1.out_ready = drv_or[1];
  assign bus2.in_valid = drv_iv[2];  assign bus2.x = drv_x[2][15:0];  assign bus2.y = drv_y[2][15:0];
  assign bus2.c_in = drv_c[2];       assign bus2.out_ready = drv_or[2];
  assign bus3.in_valid = drv_iv[3];  assign bus3.x = drv_x[3][15:0];  assign bus3.y = drv_y[3][15:0];
  assign bus3.c_in = drv_c[3];       assign bus3.out_ready = drv_or[3];

  assign obs_s[0] = bus0.s;           assign obs_co[0] = bus0.c_out;
  assign obs_s[1] = bus1.s;           assign obs_co[1] = bus1.c_out;
  assign obs_s[2] = {16'h0, bus2.s};  assign obs_co[2] = bus2.c_out;
  assign obs_s[3] = {16'h0, bus3.s};  assign obs_co[3] = bus3.c_out;
  assign obs_ov[0] = bus0.out_valid;  assign obs_ir[0] = bus0.in_ready;
  assign obs_ov[1] = bus1.out_valid;  assign obs_ir[1] = bus1.in_ready;
  assign obs_ov[2] = bus2.out_valid;  assign obs_ir[2] = bus2.in_ready;
  assign obs_ov[3] = bus3.out_valid;  assign obs_ir[3] = bus3.in_ready;

  function automatic int nch_of(input int k);
    case (k)
      0: return 4;
      1: return 1;
      2: return 16;
      default: return 4;
    endcase
  endfunction

  function automatic int width_of(input int k);
    return (k < 2) ? 32 : 16;
  endfunction

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete operation on instance k with 'stall' cycles of backpressure.
  task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic ci, input int stall, input string tag);
    logic [32:0] full;
    logic [31:0] exp_s;
    logic        exp_c;
    int          lat;
    int          guard;
    full = {1'b0, a} + {1'b0, b} + {32'h0, ci};
    if (width_of(k) == 16) begin
      exp_s = {16'h0, full[15:0]};
      exp_c = full[16];
    end else begin
      exp_s = full[31:0];
      exp_c = full[32];
    end
    guard = 0;
    while (obs_ir[k] !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    n_cmp++;
    if (obs_ir[k] !== 1'b1) begin
      n_bad++;
      $display("FAIL %s ready_wait: in_ready=%b want 1", tag, obs_ir[k]);
    end
    drv_x[k] = a; drv_y[k] = b; drv_c[k] = ci; drv_iv[k] = 1'b1;
    tick();
    drv_iv[k] = 1'b0;
    drv_x[k] = ~a; drv_y[k] = ~b; drv_c[k] = ~ci;
    lat = 0;
    while (obs_ov[k] !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    n_cmp++;
    if (lat != nch_of(k)) begin
      n_bad++;
      $display("FAIL %s latency: got %0d edges want %0d", tag, lat, nch_of(k));
    end
    repeat (stall) tick();
    n_cmp++;
    if (obs_ov[k] !== 1'b1 || obs_s[k] !== exp_s || obs_co[k] !== exp_c) begin
      n_bad++;
      $display("FAIL %s result: got ov=%b s=%h c_out=%b want ov=1 s=%h c_out=%b",
               tag, obs_ov[k], obs_s[k], obs_co[k], exp_s, exp_c);
    end
    drv_or[k] = 1'b1;
    tick();
    drv_or[k] = 1'b0;
    n_cmp++;
    if (obs_ov[k] !== 1'b0 || obs_ir[k] !== 1'b1) begin
      n_bad++;
      $display("FAIL %s release: got ov=%b in_ready=%b want ov=0 in_ready=1",
               tag, obs_ov[k], obs_ir[k]);
    end
    $display("op %s: x=%h y=%h c_in=%b -> s=%h c_out=%b lat=%0d stall=%0d",
             tag, a, b, ci, obs_s[k], obs_co[k], lat, stall);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (obs_ir[k] !== 1'b1 || obs_ov[k] !== 1'b0 || obs_s[k] !== 32'h0 || obs_co[k] !== 1'b0) begin
        n_bad++;
        $display("FAIL reset_state[%0d]: got ir=%b ov=%b s=%h c_out=%b want ir=1 ov=0 s=0 c_out=0",
                 k, obs_ir[k], obs_ov[k], obs_s[k], obs_co[k]);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    $display("reset: all instances idle");
  endtask

  task automatic test_carry_chain();
    run_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, "carry_chain");
    run_op(0, 32'h00FF_00FF, 32'h0001_0001, 1'b0, 0, "chunk_carry");
    run_op(0, 32'h0000_0000, 32'h0000_0000, 1'b1, 0, "cin_path");
  endtask

  task automatic test_backpressure();
    int guard;
    drv_x[0] = 32'h1111_1111; drv_y[0] = 32'h2222_2222; drv_c[0] = 1'b0;
    drv_iv[0] = 1'b1;
    tick();
    guard = 0;
    while (obs_ov[0] !== 1'b1 && guard < 100) begin
      drv_x[0] = ~drv_x[0];
      tick();
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      drv_x[0] = drv_x[0] + 32'h0101_0101;
      drv_y[0] = ~drv_y[0];
      drv_c[0] = ~drv_c[0];
      n_cmp++;
      if (obs_ov[0] !== 1'b1 || obs_ir[0] !== 1'b0 || obs_s[0] !== 32'h3333_3333 || obs_co[0] !== 1'b0) begin
        n_bad++;
        $display("FAIL backpressure[%0d]: got ov=%b ir=%b s=%h c_out=%b want ov=1 ir=0 s=33333333 c_out=0",
                 i, obs_ov[0], obs_ir[0], obs_s[0], obs_co[0]);
      end
      tick();
    end
    drv_or[0] = 1'b1;
    tick();
    drv_iv[0] = 1'b0;
    drv_or[0] = 1'b0;
    n_cmp++;
    if (obs_ov[0] !== 1'b0 || obs_ir[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL backpressure_release: got ov=%b ir=%b want ov=0 ir=1", obs_ov[0], obs_ir[0]);
    end
    tick();
    n_cmp++;
    if (obs_ir[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL backpressure_idle: got ir=%b want 1", obs_ir[0]);
    end
    $display("backpressure: held 5 cycles, released s=%h", obs_s[0]);
  endtask

  task automatic test_async_reset();
    drv_x[0] = 32'h1234_5678; drv_y[0] = 32'h9ABC_DEF0; drv_c[0] = 1'b0;
    drv_iv[0] = 1'b1;
    tick();
    drv_iv[0] = 1'b0;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs_s[0] !== 32'h0 || obs_co[0] !== 1'b0 || obs_ov[0] !== 1'b0 || obs_ir[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL async_reset: got s=%h c_out=%b ov=%b ir=%b want s=0 c_out=0 ov=0 ir=1",
               obs_s[0], obs_co[0], obs_ov[0], obs_ir[0]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_op(0, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 0, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [31:0] xa [3];
    logic [31:0] ya [3];
    logic        ca [3];
    logic [31:0] es [3];
    logic        ec [3];
    int acc, res, last_acc;
    xa[0] = 32'h0102_0304; ya[0] = 32'h1020_3040; ca[0] = 1'b0; es[0] = 32'h1122_3344; ec[0] = 1'b0;
    xa[1] = 32'hFFFF_0000; ya[1] = 32'h0000_FFFF; ca[1] = 1'b1; es[1] = 32'h0000_0000; ec[1] = 1'b1;
    xa[2] = 32'h8000_0000; ya[2] = 32'h8000_0000; ca[2] = 1'b1; es[2] = 32'h0000_0001; ec[2] = 1'b1;
    acc = 0; res = 0; last_acc = -1;
    drv_or[0] = 1'b1;
    drv_x[0] = xa[0]; drv_y[0] = ya[0]; drv_c[0] = ca[0]; drv_iv[0] = 1'b1;
    for (int cyc = 0; cyc < 60 && res < 3; cyc++) begin
      logic accepting;
      accepting = 1'b0;
      if (obs_ov[0] === 1'b1) begin
        n_cmp++;
        if (obs_s[0] !== es[res] || obs_co[0] !== ec[res]) begin
          n_bad++;
          $display("FAIL b2b_result[%0d]: got s=%h c_out=%b want s=%h c_out=%b",
                   res, obs_s[0], obs_co[0], es[res], ec[res]);
        end
        $display("b2b result %0d: s=%h c_out=%b", res, obs_s[0], obs_co[0]);
        res++;
      end
      if (obs_ir[0] === 1'b1 && acc < 3) begin
        accepting = 1'b1;
        if (last_acc >= 0) begin
          n_cmp++;
          if (cyc - last_acc != 6) begin
            n_bad++;
            $display("FAIL b2b_spacing[%0d]: got %0d cycles want 6", acc, cyc - last_acc);
          end
        end
        last_acc = cyc;
      end
      tick();
      if (accepting) begin
        acc++;
        if (acc < 3) begin
          drv_x[0] = xa[acc]; drv_y[0] = ya[acc]; drv_c[0] = ca[acc];
        end else begin
          drv_iv[0] = 1'b0;
        end
      end
    end
    drv_iv[0] = 1'b0;
    drv_or[0] = 1'b0;
    n_cmp++;
    if (acc != 3 || res != 3) begin
      n_bad++;
      $display("FAIL b2b_count: got accepts=%0d results=%0d want 3 and 3", acc, res);
    end
    tick();
  endtask

  task automatic test_random(input int k);
    logic [31:0] a, b, mask;
    logic        ci;
    mask = (width_of(k) == 16) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    for (int i = 0; i < 1000; i++) begin
      a  = $urandom() & mask;
      b  = $urandom() & mask;
      ci = 1'($urandom_range(0, 1));
      run_op(k, a, b, ci, int'($urandom_range(0, 3)), $sformatf("rand_cfg%0d_%0d", k, i));
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) begin
      drv_x[k] = '0; drv_y[k] = '0; drv_c[k] = 1'b0; drv_iv[k] = 1'b0; drv_or[k] = 1'b0;
    end
    test_reset();
    test_carry_chain();
    test_backpressure();
    test_async_reset();
    test_back_to_back();
    for (int k = 0; k < 4; k++) test_random(k);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit so a stuck handshake cannot hang the run.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end
endmodule
